// File: rtl/qea.sv
// State-vector quantum emulation engine: fetches gate contexts from CTX RAM and applies
// (controlled) single-qubit complex matrices to a PE_NUM-banked amplitude RAM.
module qea #(
  parameter int unsigned PE_NUM_WIDTH            = 2,
  parameter int unsigned PE_NUM                  = 4,
  parameter int unsigned DATA_WIDTH              = 32,
  parameter int unsigned MAX_QBIT_WIDTH          = 6,
  parameter int unsigned ALU_DATA_WIDTH          = DATA_WIDTH,
  parameter int unsigned STATE_DATA_WIDTH        = 2*DATA_WIDTH,
  parameter int unsigned STATE_ADDR_WIDTH        = 16,
  parameter int unsigned GATE_DATA_WIDTH         = 2*DATA_WIDTH,
  parameter int unsigned GATE_ADDR_WIDTH         = 6,
  parameter int unsigned GATE_CONTEXT_DATA_WIDTH = 2*DATA_WIDTH,
  parameter int unsigned GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int unsigned NUM_FRAC_BIT            = 30
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_start,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic                                 i_ctx_en,
  input  logic                                 i_ctx_wea,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ctx_addr,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
  input  logic                                 i_state_ena,
  input  logic                                 i_state_wea,
  input  logic [STATE_ADDR_WIDTH-1:0]          i_state_addra,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dina,
  output logic                                 o_complete,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dout
);

  localparam int unsigned KW   = PE_NUM_WIDTH + STATE_ADDR_WIDTH;
  localparam int unsigned DW   = DATA_WIDTH;
  localparam int unsigned SW   = STATE_DATA_WIDTH;
  localparam int unsigned PW   = 2*ALU_DATA_WIDTH;
  localparam int unsigned QW   = MAX_QBIT_WIDTH;
  localparam int unsigned CW   = GATE_CONTEXT_ADDR_WIDTH;
  localparam int unsigned GBUF = 1 << ((GATE_ADDR_WIDTH < 2) ? GATE_ADDR_WIDTH : 2);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_RD0, S_RD1, S_CAP, S_WR0, S_WR1, S_DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [CW-1:0]              pc_q, pc_d;
  logic [2:0]                 fcnt_q, fcnt_d;
  logic                       op_q, op_d;
  logic [QW-1:0]              ctl_q, ctl_d, tgt_q, tgt_d, nq_q, nq_d;
  logic [GATE_DATA_WIDTH-1:0] u_q [GBUF];
  logic [GATE_DATA_WIDTH-1:0] u_d [GBUF];
  logic [KW-1:0]              j_q, j_d;
  logic [SW-1:0]              a0_q, a0_d, a1_q, a1_d;
  logic                       complete_q, complete_d;
  logic [PE_NUM*SW-1:0]       dout_q;

  logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_mem [2**CW];
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_q;
  logic [SW-1:0]                      state_mem [PE_NUM][2**STATE_ADDR_WIDTH];
  logic [SW-1:0]                      eng_rd_q [PE_NUM];

  logic                        ctx_we_c, host_rd_c, adv_c;
  logic [PE_NUM-1:0]           mem_we_c;
  logic [STATE_ADDR_WIDTH-1:0] mem_addr_c;
  logic [SW-1:0]               mem_wdata_c [PE_NUM];
  logic [KW-1:0]               low_mask_c, k0_c, k1_c;
  logic                        ctl_hit_c, last_c;
  logic [SW-1:0]               res0_c, res1_c;
  logic [3:0]                  opc_c;

  function automatic logic signed [PW-1:0] sx(input logic [DW-1:0] x);
    return {{(PW-DW){x[DW-1]}}, x};
  endfunction

  // ua*a + ub*b on {re,im} pairs; all four products summed before the single rescale
  function automatic logic [SW-1:0] cmac(input logic [GATE_DATA_WIDTH-1:0] ua,
                                         input logic [SW-1:0] a,
                                         input logic [GATE_DATA_WIDTH-1:0] ub,
                                         input logic [SW-1:0] b);
    logic signed [PW-1:0] re_s, im_s;
    logic [DW-1:0]        re_o, im_o;
    re_s = sx(ua[2*DW-1:DW]) * sx(a[2*DW-1:DW]) - sx(ua[DW-1:0]) * sx(a[DW-1:0])
         + sx(ub[2*DW-1:DW]) * sx(b[2*DW-1:DW]) - sx(ub[DW-1:0]) * sx(b[DW-1:0]);
    im_s = sx(ua[2*DW-1:DW]) * sx(a[DW-1:0]) + sx(ua[DW-1:0]) * sx(a[2*DW-1:DW])
         + sx(ub[2*DW-1:DW]) * sx(b[DW-1:0]) + sx(ub[DW-1:0]) * sx(b[2*DW-1:DW]);
    re_o = DW'(re_s >>> NUM_FRAC_BIT);
    im_o = DW'(im_s >>> NUM_FRAC_BIT);
    return {re_o, im_o};
  endfunction

  // Pair index j with a zero inserted at the target bit gives the lower amplitude index
  assign low_mask_c = (KW'(1) << tgt_q) - KW'(1);
  assign k0_c       = ((j_q & ~low_mask_c) << 1) | (j_q & low_mask_c);
  assign k1_c       = k0_c | (KW'(1) << tgt_q);
  assign ctl_hit_c  = ((k0_c >> ctl_q) & KW'(1)) != '0;
  assign last_c     = j_q == ((KW'(1) << (nq_q - QW'(1))) - KW'(1));
  assign res0_c     = cmac(u_q[0], a0_q, u_q[1], a1_q);
  assign res1_c     = cmac(u_q[2], a0_q, u_q[3], a1_q);
  assign opc_c      = ctx_q[GATE_CONTEXT_DATA_WIDTH-1 -: 4];

  always_ff @(posedge clk) begin
    if (ctx_we_c) ctx_mem[i_ctx_addr] <= i_ctx_data;
    ctx_q <= ctx_mem[pc_q];
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < PE_NUM; p++) begin
      if (mem_we_c[p]) state_mem[p][mem_addr_c] <= mem_wdata_c[p];
      eng_rd_q[p] <= state_mem[p][mem_addr_c];
    end
  end

  // Host read is read-first: returns the word as it was before any same-cycle write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (host_rd_c) begin
      for (int p = 0; p < PE_NUM; p++) dout_q[(PE_NUM-p)*SW-1 -: SW] <= state_mem[p][mem_addr_c];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      fcnt_q     <= '0;
      op_q       <= 1'b0;
      ctl_q      <= '0;
      tgt_q      <= '0;
      nq_q       <= '0;
      u_q        <= '{default: '0};
      j_q        <= '0;
      a0_q       <= '0;
      a1_q       <= '0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fcnt_q     <= fcnt_d;
      op_q       <= op_d;
      ctl_q      <= ctl_d;
      tgt_q      <= tgt_d;
      nq_q       <= nq_d;
      u_q        <= u_d;
      j_q        <= j_d;
      a0_q       <= a0_d;
      a1_q       <= a1_d;
      complete_q <= complete_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fcnt_d     = fcnt_q;
    op_d       = op_q;
    ctl_d      = ctl_q;
    tgt_d      = tgt_q;
    nq_d       = nq_q;
    u_d        = u_q;
    j_d        = j_q;
    a0_d       = a0_q;
    a1_d       = a1_q;
    complete_d = complete_q;
    ctx_we_c   = 1'b0;
    host_rd_c  = 1'b0;
    adv_c      = 1'b0;
    mem_we_c   = '0;
    mem_addr_c = i_state_addra;
    for (int p = 0; p < PE_NUM; p++) mem_wdata_c[p] = i_state_dina[(PE_NUM-p)*SW-1 -: SW];

    unique case (state_q)
      S_IDLE: begin
        ctx_we_c  = i_ctx_en && i_ctx_wea;
        host_rd_c = i_state_ena;
        if (i_state_ena && i_state_wea) mem_we_c = '1;
        if (i_start) begin
          state_d    = S_FETCH;
          pc_d       = '0;
          fcnt_d     = '0;
          complete_d = 1'b0;
          nq_d       = i_qbit_num;
        end
      end
      // Registered ctx read: the word addressed in cycle c appears in ctx_q at cycle c+1
      S_FETCH: begin
        unique case (fcnt_q)
          3'd0: begin
            pc_d   = pc_q + CW'(1);
            fcnt_d = 3'd1;
          end
          3'd1: begin
            if (opc_c == 4'h0 || opc_c == 4'h1) begin
              op_d   = opc_c == 4'h1;
              ctl_d  = ctx_q[8 +: QW];
              tgt_d  = ctx_q[0 +: QW];
              pc_d   = pc_q + CW'(1);
              fcnt_d = 3'd2;
            end else begin
              state_d = S_DONE;
            end
          end
          3'd5: begin
            u_d[GBUF-1] = ctx_q;
            j_d         = '0;
            state_d     = S_RD0;
          end
          default: begin
            u_d[2'(fcnt_q - 3'd2)] = ctx_q;
            pc_d                   = pc_q + CW'(1);
            fcnt_d                 = fcnt_q + 3'd1;
          end
        endcase
      end
      S_RD0: begin
        if (op_q && !ctl_hit_c) begin
          adv_c = 1'b1;
        end else begin
          mem_addr_c = k0_c[KW-1:PE_NUM_WIDTH];
          state_d    = S_RD1;
        end
      end
      S_RD1: begin
        mem_addr_c = k1_c[KW-1:PE_NUM_WIDTH];
        a0_d       = eng_rd_q[k0_c[PE_NUM_WIDTH-1:0]];
        state_d    = S_CAP;
      end
      S_CAP: begin
        a1_d    = eng_rd_q[k1_c[PE_NUM_WIDTH-1:0]];
        state_d = S_WR0;
      end
      S_WR0: begin
        mem_addr_c                          = k0_c[KW-1:PE_NUM_WIDTH];
        mem_we_c[k0_c[PE_NUM_WIDTH-1:0]]    = 1'b1;
        for (int p = 0; p < PE_NUM; p++) mem_wdata_c[p] = res0_c;
        state_d                             = S_WR1;
      end
      S_WR1: begin
        mem_addr_c                          = k1_c[KW-1:PE_NUM_WIDTH];
        mem_we_c[k1_c[PE_NUM_WIDTH-1:0]]    = 1'b1;
        for (int p = 0; p < PE_NUM; p++) mem_wdata_c[p] = res1_c;
        adv_c                               = 1'b1;
      end
      S_DONE: begin
        complete_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (adv_c) begin
      if (last_c) begin
        state_d = S_FETCH;
        fcnt_d  = '0;
      end else begin
        j_d     = j_q + KW'(1);
        state_d = S_RD0;
      end
    end

    // A reset cycle must not disturb RAM contents
    if (!rst_n) begin
      ctx_we_c  = 1'b0;
      host_rd_c = 1'b0;
      mem_we_c  = '0;
    end
  end

  assign o_complete   = complete_q;
  assign o_state_dout = dout_q;

endmodule

// File: tb/tb_qea.sv
// Scoreboarded bench for qea: host reads push expected words, a monitor checks the returned data.
module tb_qea;
  localparam int unsigned WW = 256;
  localparam logic [63:0] ONE  = 64'h40000000_00000000;
  localparam logic [63:0] HP   = 64'h2D413CCC_00000000;
  localparam logic [63:0] HN   = 64'hD2BEC334_00000000;
  localparam logic [63:0] ENDW = 64'hF000_0000_0000_0000;

  logic          clk = 1'b0;
  logic          rst_n, start, ctx_en, ctx_wea, state_ena, state_wea, complete;
  logic [5:0]    qbit_num;
  logic [15:0]   ctx_addr, state_addra;
  logic [63:0]   ctx_data;
  logic [WW-1:0] state_dina, state_dout;

  always #5 clk = ~clk;

  qea dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_qbit_num(qbit_num),
    .i_ctx_en(ctx_en), .i_ctx_wea(ctx_wea), .i_ctx_addr(ctx_addr), .i_ctx_data(ctx_data),
    .i_state_ena(state_ena), .i_state_wea(state_wea), .i_state_addra(state_addra),
    .i_state_dina(state_dina), .o_complete(complete), .o_state_dout(state_dout)
  );

  int total = 0;
  int bad   = 0;
  logic [WW-1:0] exp_q [$];
  string         name_q [$];
  logic          rd_issue = 1'b0;
  logic          rd_issue_d = 1'b0;
  logic [63:0]   ms [64];
  logic [63:0]   prog [$];

  always @(posedge clk) rd_issue_d <= rd_issue;

  // Monitor: the DUT presents read data the cycle after a host read
  always @(negedge clk) begin : mon
    logic [WW-1:0] e;
    string nm;
    if (rd_issue_d) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected: got %h expected none", state_dout);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (state_dout !== e) begin
          bad++;
          $display("FAIL %s: got %h expected %h", nm, state_dout, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [WW-1:0] got, input logic [WW-1:0] e);
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic st_write(input int a, input logic [WW-1:0] d);
    state_ena = 1'b1; state_wea = 1'b1; state_addra = 16'(a); state_dina = d;
    tick();
    state_ena = 1'b0; state_wea = 1'b0;
  endtask

  task automatic st_read(input int a, input logic [WW-1:0] e, input string nm, input logic we,
                         input logic [WW-1:0] d);
    state_ena = 1'b1; state_wea = we; state_addra = 16'(a); state_dina = d; rd_issue = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    tick();
    state_ena = 1'b0; state_wea = 1'b0; rd_issue = 1'b0;
  endtask

  task automatic ctx_write(input int a, input logic [63:0] d);
    ctx_en = 1'b1; ctx_wea = 1'b1; ctx_addr = 16'(a); ctx_data = d;
    tick();
    ctx_en = 1'b0; ctx_wea = 1'b0;
  endtask

  function automatic longint re_of(input logic [63:0] x);
    return longint'($signed(x[63:32]));
  endfunction
  function automatic longint im_of(input logic [63:0] x);
    return longint'($signed(x[31:0]));
  endfunction

  function automatic logic [63:0] cpx(input logic [63:0] u0, input logic [63:0] a0,
                                      input logic [63:0] u1, input logic [63:0] a1);
    longint r, i;
    r = re_of(u0)*re_of(a0) - im_of(u0)*im_of(a0) + re_of(u1)*re_of(a1) - im_of(u1)*im_of(a1);
    i = re_of(u0)*im_of(a0) + im_of(u0)*re_of(a0) + re_of(u1)*im_of(a1) + im_of(u1)*re_of(a1);
    r = r >>> 30;
    i = i >>> 30;
    return {r[31:0], i[31:0]};
  endfunction

  // Reference: walk every basis index, act on those with target clear (and control set)
  task automatic model_gate(input bit cop, input int c, input int t, input int n,
                            input logic [63:0] u0, input logic [63:0] u1,
                            input logic [63:0] u2, input logic [63:0] u3);
    logic [63:0] a0, a1;
    for (int k = 0; k < (1 << n); k++) begin
      if (((k >> t) & 1) == 0 && (!cop || ((k >> c) & 1) == 1)) begin
        a0 = ms[k];
        a1 = ms[k | (1 << t)];
        ms[k]            = cpx(u0, a0, u1, a1);
        ms[k | (1 << t)] = cpx(u2, a0, u3, a1);
      end
    end
  endtask

  task automatic add_gate(input bit cop, input int c, input int t, input int n,
                          input logic [63:0] u0, input logic [63:0] u1,
                          input logic [63:0] u2, input logic [63:0] u3);
    prog.push_back({(cop ? 4'h1 : 4'h0), 46'b0, 6'(c), 2'b0, 6'(t)});
    prog.push_back(u0); prog.push_back(u1); prog.push_back(u2); prog.push_back(u3);
    model_gate(cop, c, t, n, u0, u1, u2, u3);
  endtask

  function automatic logic [WW-1:0] word_of(input int w);
    return {ms[4*w], ms[4*w+1], ms[4*w+2], ms[4*w+3]};
  endfunction

  task automatic load_state(input int n);
    for (int w = 0; w < (1 << n) / 4; w++) st_write(w, word_of(w));
  endtask

  task automatic check_state(input int n, input string nm);
    for (int w = 0; w < (1 << n) / 4; w++)
      st_read(w, word_of(w), $sformatf("%s_w%0d", nm, w), 1'b0, '0);
  endtask

  task automatic write_prog();
    for (int i = 0; i < prog.size(); i++) ctx_write(i, prog[i]);
  endtask

  task automatic run_prog(input int n, input int bound, input string nm, input bit extra_start);
    bit ok;
    ok = 1'b0;
    qbit_num = 6'(n);
    start = 1'b1;
    tick();
    for (int i = 0; i < bound; i++) begin
      start = (extra_start && i == 3);
      tick();
      if (complete) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_complete: got 0 expected 1 within %0d cycles", nm, bound);
    end
  endtask

  function automatic logic [31:0] rnd32();
    int v;
    v = int'($urandom_range(0, 32'h4000_0000)) - 32'sh2000_0000;
    return 32'(v);
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; qbit_num = 6'd3; ctx_en = 1'b0; ctx_wea = 1'b0;
    ctx_addr = '0; ctx_data = '0; state_ena = 1'b0; state_wea = 1'b0; state_addra = '0;
    state_dina = '0;
    repeat (3) tick();
    chk("rst_complete", WW'(complete), '0);
    chk("rst_dout", state_dout, '0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_complete", WW'(complete), '0);

    // Host port: plain write/read and read-first behaviour
    st_write(5, {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                 64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0001});
    st_read(5, {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0001}, "port_rd", 1'b0, '0);
    st_read(5, {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0001}, "port_rmw_old", 1'b1,
            {4{64'hA5A5_5A5A_0F0F_F0F0}});
    st_read(5, {4{64'hA5A5_5A5A_0F0F_F0F0}}, "port_rd_new", 1'b0, '0);

    // Hadamard on q0 of |000>
    st_write(0, {ONE, 64'h0, 64'h0, 64'h0});
    st_write(1, '0);
    prog.delete();
    prog.push_back(64'h0); prog.push_back(HP); prog.push_back(HP);
    prog.push_back(HP); prog.push_back(HN); prog.push_back(ENDW);
    write_prog();
    run_prog(3, 200, "h", 1'b0);
    st_read(0, {HP, HP, 64'h0, 64'h0}, "h_w0", 1'b0, '0);
    st_read(1, '0, "h_w1", 1'b0, '0);

    // Controlled-X (ctrl q0, tgt q1): control set moves |001> to |011>
    st_write(0, {64'h0, ONE, 64'h0, 64'h0});
    prog.delete();
    prog.push_back({4'h1, 46'b0, 6'd0, 2'b0, 6'd1});
    prog.push_back(64'h0); prog.push_back(ONE); prog.push_back(ONE); prog.push_back(64'h0);
    prog.push_back(ENDW);
    write_prog();
    run_prog(3, 200, "cx1", 1'b0);
    st_read(0, {64'h0, 64'h0, 64'h0, ONE}, "cx1_w0", 1'b0, '0);
    st_read(1, '0, "cx1_w1", 1'b0, '0);
    st_write(0, {ONE, 64'h0, 64'h0, 64'h0});
    run_prog(3, 200, "cx0", 1'b0);
    st_read(0, {ONE, 64'h0, 64'h0, 64'h0}, "cx0_w0", 1'b0, '0);

    // Empty program
    ctx_write(0, ENDW);
    run_prog(3, 8, "empty", 1'b0);
    st_read(0, {ONE, 64'h0, 64'h0, 64'h0}, "empty_w0", 1'b0, '0);

    // Random programs against the reference model, with a stray start during each run
    for (int it = 0; it < 6; it++) begin
      int n, ng, c, t;
      bit cop;
      n  = $urandom_range(3, 6);
      ng = $urandom_range(1, 5);
      for (int k = 0; k < 64; k++) ms[k] = (k < (1 << n)) ? {rnd32(), rnd32()} : 64'h0;
      load_state(n);
      prog.delete();
      for (int g = 0; g < ng; g++) begin
        cop = 1'($urandom_range(0, 1));
        t = $urandom_range(0, n - 1);
        c = $urandom_range(0, n - 1);
        while (c == t) c = $urandom_range(0, n - 1);
        add_gate(cop, c, t, n, {rnd32(), rnd32()}, {rnd32(), rnd32()},
                 {rnd32(), rnd32()}, {rnd32(), rnd32()});
      end
      prog.push_back(($urandom_range(0, 1) == 1) ? 64'h7000_0000_0000_0000 : ENDW);
      write_prog();
      run_prog(n, 4000, $sformatf("rand%0d", it), 1'b1);
      check_state(n, $sformatf("rand%0d", it));
    end

    // Reset in the middle of a run
    prog.delete();
    for (int g = 0; g < 4; g++) add_gate(1'b0, 0, g, 6, HP, HP, HP, HN);
    prog.push_back(ENDW);
    write_prog();
    qbit_num = 6'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_complete", WW'(complete), '0);
    chk("midrst_dout", state_dout, '0);
    rst_n = 1'b1;
    tick();
    ctx_write(0, ENDW);
    run_prog(3, 8, "after_rst", 1'b0);

    repeat (3) tick();
    chk("scoreboard_drained", WW'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
